// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with two-entry skid buffer, bubble fill and saturating stall counter
module pipe_skid_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_main, r_skid;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready, r_out_valid;
  logic              w_in_fire, w_out_fire, w_stall;
  assign w_in_fire   = in_valid_i & r_in_ready;
  assign w_out_fire  = r_out_valid & out_ready_i;
  assign w_stall     = r_out_valid & ~out_ready_i & ~flush_i;
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_main;
  assign stall_cnt_o = r_cnt;
  // ready/valid flags are kept as their own flops so in_ready_o has no path from out_ready_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= EMPTY;
      r_main      <= BUBBLE_VAL;
      r_skid      <= BUBBLE_VAL;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_stall && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      if (flush_i) begin
        r_state     <= EMPTY;
        r_main      <= BUBBLE_VAL;
        r_skid      <= BUBBLE_VAL;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          EMPTY: if (w_in_fire) begin
            r_main      <= in_data_i;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
          ONE: begin
            if (w_in_fire && w_out_fire) r_main <= in_data_i;
            else if (w_out_fire) begin
              r_main      <= BUBBLE_VAL;
              r_state     <= EMPTY;
              r_out_valid <= 1'b0;
            end else if (w_in_fire) begin
              r_skid     <= in_data_i;
              r_state    <= FULL;
              r_in_ready <= 1'b0;
            end
          end
          FULL: if (w_out_fire) begin
            r_main     <= r_skid;
            r_skid     <= BUBBLE_VAL;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
          default: begin
            r_state     <= EMPTY;
            r_main      <= BUBBLE_VAL;
            r_skid      <= BUBBLE_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed checks of pipe_skid_reg; u1 uses a NOP bubble and a 4-bit counter
module tb_pipe_skid_reg;
  logic       clk, rst, flush, iv, ordy;
  logic [7:0] idat;
  logic       rdy0, vld0, rdy1, vld1;
  logic [7:0] dat0, dat1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  int total = 0, passed = 0;

  pipe_skid_reg #(.DATA_W(8), .CNT_W(16)) u0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(rdy0),
    .in_data_i(idat), .out_valid_o(vld0), .out_ready_i(ordy), .out_data_o(dat0), .stall_cnt_o(cnt0));
  pipe_skid_reg #(.DATA_W(8), .BUBBLE_VAL(8'h13), .CNT_W(4)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(rdy1),
    .in_data_i(idat), .out_valid_o(vld1), .out_ready_i(ordy), .out_data_o(dat1), .stall_cnt_o(cnt1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; idat = 8'h00;
    #2;
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_data", 32'(dat0), 32'h00);
    chk("rst_data_nop", 32'(dat1), 32'h13);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    #10 rst = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv = 1'b1; idat = 8'h11 + 8'(i);
      tick();
      chk("stream_valid", 32'(vld0), 32'd1);
      chk("stream_data", 32'(dat0), 32'h11 + 32'(i));
      chk("stream_ready", 32'(rdy0), 32'd1);
    end
    iv = 1'b0;
    tick();
    chk("drain_valid", 32'(vld0), 32'd0);
    chk("drain_data", 32'(dat0), 32'h00);
    chk("bubble_nop", 32'(dat1), 32'h13);
    chk("bubble_nop_valid", 32'(vld1), 32'd0);
    chk("stream_cnt", 32'(cnt0), 32'd0);
    iv = 1'b1; idat = 8'hA1;
    tick();
    chk("bp_a1", 32'(dat0), 32'hA1);
    ordy = 1'b0; idat = 8'hA2;
    tick();
    chk("bp_skid_ready", 32'(rdy0), 32'd0);
    chk("bp_hold_a1", 32'(dat0), 32'hA1);
    chk("bp_cnt1", 32'(cnt0), 32'd1);
    idat = 8'hA3;
    tick();
    chk("bp_stall2_data", 32'(dat0), 32'hA1);
    chk("bp_stall2_ready", 32'(rdy0), 32'd0);
    tick();
    chk("bp_stall3_valid", 32'(vld0), 32'd1);
    chk("bp_cnt3", 32'(cnt0), 32'd3);
    ordy = 1'b1;
    tick();
    chk("bp_a2", 32'(dat0), 32'hA2);
    chk("bp_recover_ready", 32'(rdy0), 32'd1);
    tick();
    chk("bp_a3", 32'(dat0), 32'hA3);
    iv = 1'b0;
    tick();
    chk("bp_empty", 32'(vld0), 32'd0);
    chk("bp_cnt_final", 32'(cnt0), 32'd3);
    ordy = 1'b0; iv = 1'b1; idat = 8'hB1;
    tick();
    idat = 8'hB2;
    tick();
    chk("fl_full", 32'(rdy0), 32'd0);
    flush = 1'b1; idat = 8'hB5; ordy = 1'b1;
    tick();
    chk("fl_valid", 32'(vld0), 32'd0);
    chk("fl_data", 32'(dat0), 32'h00);
    chk("fl_data_nop", 32'(dat1), 32'h13);
    chk("fl_ready", 32'(rdy0), 32'd1);
    chk("fl_cnt", 32'(cnt0), 32'd4);
    flush = 1'b0; iv = 1'b0;
    tick();
    chk("fl_no_b5", 32'(vld0), 32'd0);
    iv = 1'b1; idat = 8'hC1;
    tick();
    chk("fl_accept_valid", 32'(vld0), 32'd1);
    chk("fl_accept_data", 32'(dat0), 32'hC1);
    iv = 1'b0;
    tick();
    chk("fl_accept_drain", 32'(vld0), 32'd0);
    ordy = 1'b0; iv = 1'b1; idat = 8'hD1;
    tick();
    iv = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt4", 32'(cnt1), 32'd15);
    chk("sat_cnt16", 32'(cnt0), 32'd24);
    chk("sat_data_stable", 32'(dat0), 32'hD1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_cnt4", 32'(cnt1), 32'd15);
    chk("sat_flush_cnt16", 32'(cnt0), 32'd24);
    chk("sat_flush_valid", 32'(vld1), 32'd0);
    iv = 1'b1; idat = 8'hE1;
    tick();
    idat = 8'hE2;
    tick();
    chk("mid_full", 32'(rdy0), 32'd0);
    chk("mid_cnt", 32'(cnt0), 32'd25);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(vld0), 32'd0);
    chk("mid_rst_ready", 32'(rdy0), 32'd1);
    chk("mid_rst_data", 32'(dat0), 32'h00);
    chk("mid_rst_nop", 32'(dat1), 32'h13);
    chk("mid_rst_cnt", 32'(cnt0), 32'd0);
    idat = 8'hE3;
    #1 rst = 1'b0;
    tick();
    chk("rel_valid", 32'(vld0), 32'd1);
    chk("rel_data", 32'(dat0), 32'hE3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
